// File: rtl/issue_queue_if.sv
// Decode-to-launch handshake bundle for the dual-ported issue queue.
// The slave modport is the queue side; the master modport is the decode/launch side.
interface issue_queue_if #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int DC_W  = 72
);
    localparam int PW = $clog2(DEPTH);

    logic            in1_valid;
    logic [PC_W-1:0] in1_pc;
    logic [PC_W-1:0] in1_npc;
    logic [DC_W-1:0] in1_decodeout;
    logic            in2_valid;
    logic [PC_W-1:0] in2_pc;
    logic [PC_W-1:0] in2_npc;
    logic [DC_W-1:0] in2_decodeout;
    logic            in_ready;
    logic [1:0]      launch_cnt;
    logic [PC_W-1:0] out1_pc;
    logic [PC_W-1:0] out1_npc;
    logic [DC_W-1:0] out1_decodeout;
    logic            receive_flag1;
    logic [PC_W-1:0] out2_pc;
    logic [PC_W-1:0] out2_npc;
    logic [DC_W-1:0] out2_decodeout;
    logic            receive_flag2;
    logic [PW:0]     count;

    modport slave (
        input  in1_valid, in1_pc, in1_npc, in1_decodeout,
        input  in2_valid, in2_pc, in2_npc, in2_decodeout,
        input  launch_cnt,
        output in_ready,
        output out1_pc, out1_npc, out1_decodeout, receive_flag1,
        output out2_pc, out2_npc, out2_decodeout, receive_flag2,
        output count
    );

    modport master (
        output in1_valid, in1_pc, in1_npc, in1_decodeout,
        output in2_valid, in2_pc, in2_npc, in2_decodeout,
        output launch_cnt,
        input  in_ready,
        input  out1_pc, out1_npc, out1_decodeout, receive_flag1,
        input  out2_pc, out2_npc, out2_decodeout, receive_flag2,
        input  count
    );
endinterface

// File: rtl/issue_queue.sv
// Dual-ported circular instruction queue between decode and launch select.
// Up to two pushes and two pops per cycle; outputs show the two oldest entries.
module issue_queue #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32,
    parameter int DC_W  = 72
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stop,
    input  logic          flush,
    issue_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);

    logic [PC_W-1:0] pc_mem  [DEPTH];
    logic [PC_W-1:0] npc_mem [DEPTH];
    logic [DC_W-1:0] dc_mem  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [PW-1:0] head_second;
    logic [PW-1:0] wr2_idx;
    logic          accept;
    logic [1:0]    nin;
    logic [1:0]    pop_req;
    logic [1:0]    npop;

    assign bus.in_ready      = (count <= (PW+1)'(DEPTH - 2));
    assign bus.receive_flag1 = (count >= (PW+1)'(1));
    assign bus.receive_flag2 = (count >= (PW+1)'(2));
    assign bus.count         = count;

    assign accept  = bus.in_ready && !stop && !flush;
    assign nin     = accept ? ({1'b0, bus.in1_valid} + {1'b0, bus.in2_valid}) : 2'd0;
    assign pop_req = bus.launch_cnt[1] ? 2'd2 : bus.launch_cnt;
    // When fewer entries are held than requested, count fits in two bits.
    assign npop    = (stop || flush) ? 2'd0 :
                     (((PW+1)'(pop_req) > count) ? count[1:0] : pop_req);

    assign head_second = head + PW'(1);
    assign wr2_idx     = bus.in1_valid ? (tail + PW'(1)) : tail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(npop);
            tail  <= tail + PW'(nin);
            count <= count + (PW+1)'(nin) - (PW+1)'(npop);
        end
    end

    // Storage needs no reset: nothing is visible until count covers it.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (bus.in1_valid) begin
                pc_mem[tail]  <= bus.in1_pc;
                npc_mem[tail] <= bus.in1_npc;
                dc_mem[tail]  <= bus.in1_decodeout;
            end
            if (bus.in2_valid) begin
                pc_mem[wr2_idx]  <= bus.in2_pc;
                npc_mem[wr2_idx] <= bus.in2_npc;
                dc_mem[wr2_idx]  <= bus.in2_decodeout;
            end
        end
    end

    assign bus.out1_pc        = bus.receive_flag1 ? pc_mem[head]  : '0;
    assign bus.out1_npc       = bus.receive_flag1 ? npc_mem[head] : '0;
    assign bus.out1_decodeout = bus.receive_flag1 ? dc_mem[head]  : '0;
    assign bus.out2_pc        = bus.receive_flag2 ? pc_mem[head_second]  : '0;
    assign bus.out2_npc       = bus.receive_flag2 ? npc_mem[head_second] : '0;
    assign bus.out2_decodeout = bus.receive_flag2 ? dc_mem[head_second]  : '0;
endmodule
